// File: rtl/pin_bus_responder_if.sv
// Pin-level bundle between the TinyTapeout host pins and the register-file responder.
interface pin_bus_responder_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/pin_bus_responder.sv
// Device-side responder for the four-phase req/ack pin protocol: 14 RW bytes,
// a transaction counter at address 14 and a constant ID at address 15.
module pin_bus_responder #(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    pin_bus_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic [3:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  last_addr_q, last_addr_d;
    logic        lww_q, lww_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [7:0]  oe_q, oe_d;
    logic [7:0]  rd_out_q, rd_out_d;
    // Entries 14 and 15 are never written; the map serves them from cnt_q / ID_VALUE.
    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];

    logic        rise;
    logic        unused_ctrl;

    assign rise        = s2_q & ~s3_q;
    assign unused_ctrl = ^bus.ui_in[5:4];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        last_addr_d = last_addr_q;
        lww_d       = lww_q;
        mem_d       = mem_q;

        case (state_q)
            IDLE: begin
                if (rise && ena) begin
                    addr_d  = bus.ui_in[3:0];
                    we_d    = bus.ui_in[6];
                    wdata_d = bus.uio_in;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    if (addr_q <= 4'd13) begin
                        mem_d[addr_q] = wdata_q;
                    end
                end else begin
                    case (addr_q)
                        4'd14:   rdata_d = cnt_q;
                        4'd15:   rdata_d = ID_VALUE;
                        default: rdata_d = mem_q[addr_q];
                    endcase
                end
                cnt_d       = cnt_q + 8'd1;
                last_addr_d = addr_q;
                lww_d       = we_q;
                state_d     = ACK;
            end
            ACK: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop directly.
        ack_d    = (state_d == ACK);
        busy_d   = (state_d != IDLE);
        oe_d     = (state_d == ACK && !we_d) ? '1 : '0;
        rd_out_d = (state_d == ACK && !we_d) ? rdata_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s3_q        <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            lww_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= '0;
            rd_out_q    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            s1_q        <= bus.ui_in[7];
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            last_addr_q <= last_addr_d;
            lww_q       <= lww_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            rd_out_q    <= rd_out_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.uo_out  = {ack_q, busy_q, lww_q, 1'b0, last_addr_q};
    assign bus.uio_out = rd_out_q;
    assign bus.uio_oe  = oe_q;

endmodule
